// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter SDRAM read arbiter.
package blit_pkg;

   localparam int BLIT_ADDR_W      = 26;
   localparam int BLIT_BURST_WORDS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BURST = 2'd2
   } arb_state_t;

endpackage

// File: rtl/blit_sdram_arb_rr_pick.sv
// rr_pick: combinational round-robin selector. Searches req starting at
// last+1 with wrap; returns a one-hot grant, its index and an any flag.
module rr_pick #(
   parameter int NUM_CLIENTS = 2,
   parameter int IDX_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic [NUM_CLIENTS-1:0] req,
   input  logic [IDX_W-1:0]       last,
   output logic [NUM_CLIENTS-1:0] grant,
   output logic [IDX_W-1:0]       index,
   output logic                   any
);

   int unsigned      cand;
   logic [IDX_W-1:0] cidx;
   logic             found;

   // First requester at or after last+1, wrapping modulo NUM_CLIENTS
   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      cand  = 0;
      cidx  = '0;
      for (int unsigned off = 1; off <= NUM_CLIENTS; off++) begin
         cand = (32'(last) + off) % NUM_CLIENTS;
         cidx = IDX_W'(cand);
         if (!found && req[cidx]) begin
            found       = 1'b1;
            grant[cidx] = 1'b1;
            index       = cidx;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/blit_sdram_arb.sv
// blit_sdram_arb: arbitrates burst reads from NUM_CLIENTS clients onto one
// SDRAM burst-read port, holding the grant for the whole burst.
// Optional macro BLIT_ARB_PRIO0_EN gives client 0 fixed top priority.
module blit_sdram_arb
   import blit_pkg::*;
#(
   parameter int NUM_CLIENTS = 2,
   parameter int ADDR_W      = BLIT_ADDR_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_CLIENTS-1:0]        client_request,
   input  logic [NUM_CLIENTS*ADDR_W-1:0] client_address,
   output logic [NUM_CLIENTS-1:0]        client_ready,
   output logic [NUM_CLIENTS-1:0]        client_rvalid,
   output logic [NUM_CLIENTS-1:0]        client_complete,
   output logic [ADDR_W-1:0]             client_raddress,
   output logic [31:0]                   client_rdata,
   output logic                          sdram_request,
   input  logic                          sdram_ready,
   output logic [ADDR_W-1:0]             sdram_address,
   input  logic                          sdram_rvalid,
   input  logic [ADDR_W-1:0]             sdram_raddress,
   input  logic [31:0]                   sdram_rdata,
   input  logic                          sdram_complete
);

   localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

   arb_state_t             state, state_nxt;
   logic [IDX_W-1:0]       owner, last_grant;
   logic [NUM_CLIENTS-1:0] pick_req, rr_grant, win_grant;
   logic [IDX_W-1:0]       rr_idx, win_idx;
   logic                   rr_any, win_any;
   logic [ADDR_W-1:0]      addr_arr [NUM_CLIENTS];
   logic [ADDR_W-1:0]      win_addr;

   for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_addr
      assign addr_arr[g] = client_address[g*ADDR_W +: ADDR_W];
   end

`ifdef BLIT_ARB_PRIO0_EN
   // Client 0 is removed from the rotation and overrides it when requesting
   assign pick_req  = {client_request[NUM_CLIENTS-1:1], 1'b0};
   assign win_grant = client_request[0] ? NUM_CLIENTS'(1) : rr_grant;
   assign win_idx   = client_request[0] ? '0 : rr_idx;
   assign win_any   = client_request[0] | rr_any;
`else
   assign pick_req  = client_request;
   assign win_grant = rr_grant;
   assign win_idx   = rr_idx;
   assign win_any   = rr_any;
`endif

   assign win_addr = addr_arr[win_idx];

   rr_pick #(
      .NUM_CLIENTS (NUM_CLIENTS),
      .IDX_W       (IDX_W)
   ) u_rr_pick (
      .req   (pick_req),
      .last  (last_grant),
      .grant (rr_grant),
      .index (rr_idx),
      .any   (rr_any)
   );

   assign client_raddress = sdram_raddress;
   assign client_rdata    = sdram_rdata;

   // State, grant bookkeeping and registered SDRAM request/address
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         sdram_request <= 1'b0;
         sdram_address <= '0;
         owner         <= '0;
         last_grant    <= IDX_W'(NUM_CLIENTS - 1);
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (win_any) begin
                  owner         <= win_idx;
                  last_grant    <= win_idx;
                  sdram_address <= win_addr;
                  sdram_request <= 1'b1;
               end
            end
            ISSUE: begin
               if (sdram_ready) sdram_request <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Next state, accept pulse and owner-steered read strobes
   always_comb begin
      state_nxt       = state;
      client_ready    = '0;
      client_rvalid   = '0;
      client_complete = '0;
      case (state)
         IDLE: begin
            // gated by reset so every output reads 0 while reset is held
            if (win_any && reset) begin
               client_ready = win_grant;
               state_nxt    = ISSUE;
            end
         end
         ISSUE: begin
            if (sdram_ready) state_nxt = BURST;
         end
         BURST: begin
            client_rvalid[owner]   = sdram_rvalid;
            client_complete[owner] = sdram_rvalid & sdram_complete;
            if (sdram_rvalid && sdram_complete) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_blit_sdram_arb.sv
// Scoreboard bench for blit_sdram_arb: stimulus pushes expected grants and
// beats into queues; a negedge monitor pops and compares DUT strobes.
module tb_blit_sdram_arb;
   import blit_pkg::*;

   localparam int N  = 2;
   localparam int AW = BLIT_ADDR_W;

   typedef struct {
      int            client;
      logic [AW-1:0] addr;
   } grant_t;

   typedef struct {
      int            client;
      logic [31:0]   data;
      logic [AW-1:0] raddr;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  client_request;
   logic [N*AW-1:0] client_address;
   logic [N-1:0]  client_ready, client_rvalid, client_complete;
   logic [AW-1:0] client_raddress;
   logic [31:0]   client_rdata;
   logic          sdram_request, sdram_ready;
   logic [AW-1:0] sdram_address, sdram_raddress;
   logic          sdram_rvalid, sdram_complete;
   logic [31:0]   sdram_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   grant_t grant_q[$];
   beat_t  beat_q[$];

   blit_sdram_arb #(
      .NUM_CLIENTS (N),
      .ADDR_W      (AW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .client_request  (client_request),
      .client_address  (client_address),
      .client_ready    (client_ready),
      .client_rvalid   (client_rvalid),
      .client_complete (client_complete),
      .client_raddress (client_raddress),
      .client_rdata    (client_rdata),
      .sdram_request   (sdram_request),
      .sdram_ready     (sdram_ready),
      .sdram_address   (sdram_address),
      .sdram_rvalid    (sdram_rvalid),
      .sdram_raddress  (sdram_raddress),
      .sdram_rdata     (sdram_rdata),
      .sdram_complete  (sdram_complete)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      client_address = {a1, a0};
   endtask

   // Monitor: every DUT strobe must match the head of its queue
   initial begin : monitor
      grant_t        g;
      beat_t         b;
      logic          addr_pending;
      logic [AW-1:0] pend_addr;
      addr_pending = 1'b0;
      pend_addr    = '0;
      forever begin
         @(negedge clk);
         if (addr_pending) begin
            check("issue_request", 64'(sdram_request), 64'd1);
            check("issue_address", 64'(sdram_address), 64'(pend_addr));
            addr_pending = 1'b0;
         end
         if (client_ready != '0) begin
            if (grant_q.size() == 0) begin
               check("unexpected_ready", 64'(client_ready), 64'd0);
            end else begin
               g = grant_q.pop_front();
               check("grant_onehot", 64'(client_ready), 64'd1 << g.client);
               pend_addr    = g.addr;
               addr_pending = 1'b1;
            end
         end
         if (client_rvalid != '0 || client_complete != '0) begin
            if (beat_q.size() == 0) begin
               check("unexpected_rvalid", 64'(client_rvalid), 64'd0);
               check("unexpected_complete", 64'(client_complete), 64'd0);
            end else begin
               b = beat_q.pop_front();
               check("beat_rvalid", 64'(client_rvalid), 64'd1 << b.client);
               check("beat_complete", 64'(client_complete), b.last ? (64'd1 << b.client) : 64'd0);
               check("beat_rdata", 64'(client_rdata), 64'(b.data));
               check("beat_raddress", 64'(client_raddress), 64'(b.raddr));
            end
         end
      end
   end

   // One burst starting in an IDLE cycle where the caller has raised requests.
   // keep < 16 pulses reset before beat keep+1; later beats are strays.
   task automatic run_burst(input int client, input logic [AW-1:0] addr, input int delay,
                            input logic [31:0] dbase, input int keep, input bit drop);
      grant_q.push_back('{client: client, addr: addr});
      step();
      if (drop) client_request[client] = 1'b0;
      for (int k = 0; k < delay; k++) begin
         sdram_ready    = 1'b0;
         sdram_rvalid   = 1'b1;
         sdram_complete = 1'b1;
         sdram_rdata    = 32'hBAD0_0000 + k;
         #1;
         check("hold_request", 64'(sdram_request), 64'd1);
         check("hold_address", 64'(sdram_address), 64'(addr));
         step();
      end
      sdram_rvalid   = 1'b0;
      sdram_complete = 1'b0;
      sdram_ready    = 1'b1;
      step();
      check("request_dropped", 64'(sdram_request), 64'd0);
      if (delay > 0) sdram_ready = 1'b0;
      for (int b = 0; b < 16; b++) begin
         if (b == keep) begin
            reset = 1'b0;
            #1;
            check("rst_ready", 64'(client_ready), 64'd0);
            check("rst_rvalid", 64'(client_rvalid), 64'd0);
            check("rst_complete", 64'(client_complete), 64'd0);
            check("rst_sdram_request", 64'(sdram_request), 64'd0);
            check("rst_sdram_address", 64'(sdram_address), 64'd0);
            check("rst_state", 64'(dut.state), 64'(IDLE));
         end
         if (b == keep + 1) reset = 1'b1;
         sdram_rvalid   = 1'b1;
         sdram_rdata    = dbase + b;
         sdram_raddress = addr + AW'(4 * b);
         sdram_complete = (b == 15);
         if (b < keep)
            beat_q.push_back('{client: client, data: dbase + b,
                               raddr: addr + AW'(4 * b), last: (b == 15)});
         step();
      end
      sdram_rvalid   = 1'b0;
      sdram_complete = 1'b0;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int w;
      reset          = 1'b0;
      client_request = '0;
      client_address = '0;
      sdram_ready    = 1'b0;
      sdram_rvalid   = 1'b0;
      sdram_complete = 1'b0;
      sdram_raddress = '0;
      sdram_rdata    = '0;
      step();
      step();
      check("reset_ready", 64'(client_ready), 64'd0);
      check("reset_rvalid", 64'(client_rvalid), 64'd0);
      check("reset_complete", 64'(client_complete), 64'd0);
      check("reset_sdram_request", 64'(sdram_request), 64'd0);
      check("reset_sdram_address", 64'(sdram_address), 64'd0);
      check("reset_state", 64'(dut.state), 64'(IDLE));
      check("reset_owner", 64'(dut.owner), 64'd0);
      check("reset_last_grant", 64'(dut.last_grant), 64'(N - 1));
      reset = 1'b1;
      step();

      // Test 1: lone client 1 at 0x0001040, sdram_ready held high
      sdram_ready = 1'b1;
      set_addr(26'h0000000, 26'h0001040);
      client_request = 2'b10;
      run_burst(1, 26'h0001040, 0, 32'hA000_0000, 16, 1'b1);

      // Tests 2/6: both requesting continuously, last_grant=1 on entry
      set_addr(26'h0000200, 26'h0000300);
      client_request = 2'b11;
      for (int k = 0; k < 4; k++) begin
`ifdef BLIT_ARB_PRIO0_EN
         w = 0;
`else
         w = k % 2;
`endif
         run_burst(w, (w == 1) ? 26'h0000300 : 26'h0000200, 0, 32'h1000_0000 + (k << 8), 16, 1'b0);
      end
      client_request = '0;
      step();

      // Test 3: sdram_ready low for 5 ISSUE cycles with stray beats
      set_addr(26'h0000000, 26'h0ABCDE0);
      client_request = 2'b10;
      run_burst(1, 26'h0ABCDE0, 5, 32'hC000_0000, 16, 1'b1);
      step();

      // Test 4: stray beat while IDLE
      sdram_rvalid   = 1'b1;
      sdram_complete = 1'b1;
      sdram_rdata    = 32'hDEADBEEF;
      sdram_raddress = 26'h0000ABC;
      #1;
      check("stray_rvalid", 64'(client_rvalid), 64'd0);
      check("stray_complete", 64'(client_complete), 64'd0);
      check("stray_rdata", 64'(client_rdata), 64'hDEADBEEF);
      check("stray_raddress", 64'(client_raddress), 64'h0000ABC);
      step();
      check("stray_state", 64'(dut.state), 64'(IDLE));
      sdram_rvalid   = 1'b0;
      sdram_complete = 1'b0;
      step();

      // Test 5: reset after beat 7 of an unaligned-address burst
      set_addr(26'h1234567, 26'h0000000);
      client_request = 2'b01;
      run_burst(0, 26'h1234567, 0, 32'h5000_0000, 7, 1'b1);
      step();

      // After reset release: lone client 1 granted normally, back-to-back
      set_addr(26'h0000000, 26'h3FFFFFF);
      client_request = 2'b10;
      run_burst(1, 26'h3FFFFFF, 0, 32'h7000_0000, 16, 1'b0);
      run_burst(1, 26'h3FFFFFF, 0, 32'h7100_0000, 16, 1'b0);
      client_request = '0;
      step();
      step();

      check("grant_queue_drained", 64'(grant_q.size()), 64'd0);
      check("beat_queue_drained", 64'(beat_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
